second_order_sigdel: RTL and testbench

SECOND_ORDER_SIGDEL -- requirements
Module: second_order_sigdel

---
 rtl/sigdel_pkg.sv | 31 +++
 rtl/sigdel_integrator.sv | 40 ++++
 rtl/second_order_sigdel.sv | 138 +++++++++++++
 tb/tb_second_order_sigdel.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigdel_pkg.sv
// Shared types and arithmetic helpers for the sigma-delta modulator.
// Helpers work on 64-bit values, so they are exact for widths up to 62 bits.
package sigdel_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRecover
    } sigdel_state_e;

    function automatic longint fs_pos(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint fs_neg(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int unsigned w);
        longint sum;
        sum = a + b;
        if (sum > fs_pos(w)) begin
            return fs_pos(w);
        end
        if (sum < fs_neg(w)) begin
            return fs_neg(w);
        end
        return sum;
    endfunction

endpackage

// File: rtl/sigdel_integrator.sv
// Saturating accumulator stage of the modulator loop: accumulates delta when
// advanced, holds otherwise, and clear forces it to zero.
module sigdel_integrator
    import sigdel_pkg::*;
#(
    parameter int unsigned WIDTH = 26
) (
    input  logic                    mod_clock,
    input  logic                    mod_reset_n,
    input  logic                    advance,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] delta,
    output logic signed [WIDTH-1:0] acc,
    output logic signed [WIDTH-1:0] acc_next
);

    logic signed [WIDTH-1:0] acc_q, acc_d, sum_sat;

    always_comb begin
        sum_sat = WIDTH'(sat_add(longint'(acc_q), longint'(delta), WIDTH));
        acc_d   = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (advance) begin
            acc_d = sum_sat;
        end
    end

    always_ff @(posedge mod_clock or negedge mod_reset_n) begin
        if (!mod_reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc      = acc_q;
    assign acc_next = sum_sat;

endmodule

// File: rtl/second_order_sigdel.sv
// First/second-order sigma-delta modulator with run-length overload detection
// and a timed integrator-clear recovery interval.
module second_order_sigdel
    import sigdel_pkg::*;
#(
    parameter int unsigned INPUT_BITWIDTH = 24,
    parameter int unsigned ORDER          = 2,
    parameter int unsigned OVLD_LIMIT     = 64,
    parameter int unsigned RECOVER_CYCLES = 16
) (
    input  logic                      mod_clock,
    input  logic                      mod_reset_n,
    input  logic                      enable,
    input  logic [INPUT_BITWIDTH-1:0] input_sig,
    output logic                      output_sig,
    output logic                      overload,
    output logic [7:0]                ovld_count
);

    localparam int unsigned W    = INPUT_BITWIDTH;
    localparam int unsigned W1   = W + 2;
    localparam int unsigned W2   = W + 4;
    localparam int unsigned RunW = $clog2(OVLD_LIMIT + 1);
    localparam int unsigned RecW = $clog2(RECOVER_CYCLES + 1);
    localparam logic signed [W-1:0] FullPos = W'(fs_pos(W));
    localparam logic signed [W-1:0] FullNeg = W'(fs_neg(W));

    sigdel_state_e        state_q, state_d;
    logic                 out_q, out_d;
    logic [RunW-1:0]      run_q, run_d;
    logic [RecW-1:0]      rec_q, rec_d;
    logic [7:0]           ovc_q, ovc_d;

    logic signed [W-1:0]  fb;
    logic signed [W1-1:0] delta1, int1, int1_next;
    logic signed [W2-1:0] int2, int2_next;
    logic                 advance, clear, new_bit, unused_acc;

    assign fb     = out_q ? FullPos : FullNeg;
    assign delta1 = W1'($signed(input_sig)) - W1'(fb);

    sigdel_integrator #(.WIDTH(W1)) u_int1 (
        .mod_clock   (mod_clock),
        .mod_reset_n (mod_reset_n),
        .advance     (advance),
        .clear       (clear),
        .delta       (delta1),
        .acc         (int1),
        .acc_next    (int1_next)
    );

    // The quantiser looks at the last integrator's next value so the loop has no
    // extra delay beyond the output register; an extra delay makes order 2 unstable.
    if (ORDER == 2) begin : g_int2
        logic signed [W2-1:0] delta2;
        assign delta2 = W2'(int1) - W2'(fb);

        sigdel_integrator #(.WIDTH(W2)) u_int2 (
            .mod_clock   (mod_clock),
            .mod_reset_n (mod_reset_n),
            .advance     (advance),
            .clear       (clear),
            .delta       (delta2),
            .acc         (int2),
            .acc_next    (int2_next)
        );
        assign new_bit = ~int2_next[W2-1];
    end else begin : g_no_int2
        assign int2      = '0;
        assign int2_next = '0;
        assign new_bit   = ~int1_next[W1-1];
    end

    assign unused_acc = ^{int1, int1_next, int2, int2_next};

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        run_d   = run_q;
        rec_d   = rec_q;
        ovc_d   = ovc_q;
        advance = 1'b0;
        clear   = 1'b0;
        case (state_q)
            StIdle, StRun: begin
                // Overload is checked before enable so it wins a same-cycle enable drop.
                if (state_q == StRun && run_q == RunW'(OVLD_LIMIT)) begin
                    state_d = StRecover;
                    clear   = 1'b1;
                    run_d   = '0;
                    rec_d   = '0;
                    if (ovc_q != 8'hff) begin
                        ovc_d = ovc_q + 8'd1;
                    end
                end else if (enable) begin
                    state_d = StRun;
                    advance = 1'b1;
                    out_d   = new_bit;
                    run_d   = (new_bit == out_q) ? run_q + RunW'(1) : RunW'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            StRecover: begin
                clear = 1'b1;
                out_d = ~out_q;
                if (rec_q == RecW'(RECOVER_CYCLES - 1)) begin
                    rec_d   = '0;
                    state_d = enable ? StRun : StIdle;
                end else begin
                    rec_d = rec_q + RecW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mod_clock or negedge mod_reset_n) begin
        if (!mod_reset_n) begin
            state_q <= StIdle;
            out_q   <= 1'b0;
            run_q   <= '0;
            rec_q   <= '0;
            ovc_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            run_q   <= run_d;
            rec_q   <= rec_d;
            ovc_q   <= ovc_d;
        end
    end

    assign output_sig = out_q;
    assign overload   = (state_q == StRecover);
    assign ovld_count = ovc_q;

endmodule

// File: tb/tb_second_order_sigdel.sv
// Directed bench for second_order_sigdel: order-2 DUT checked against hand values
// and a behavioural loop model, plus an order-1 instance checked against a known pattern.
module tb_second_order_sigdel;
    import sigdel_pkg::*;

    localparam longint FP = 8388607;
    localparam longint FN = -8388608;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, en1;
    logic [23:0] in_sig, in1;
    logic        out2, ovl2, out1, ovl1;
    logic [7:0]  cnt2, cnt1;

    int total = 0;
    int bad   = 0;

    longint m_i1, m_i2;
    bit     m_out;
    int     m_st, m_run, m_rec, m_ovc;

    always #5 clk = ~clk;

    second_order_sigdel dut2 (
        .mod_clock   (clk),
        .mod_reset_n (rst_n),
        .enable      (en),
        .input_sig   (in_sig),
        .output_sig  (out2),
        .overload    (ovl2),
        .ovld_count  (cnt2)
    );

    second_order_sigdel #(.ORDER(1)) dut1 (
        .mod_clock   (clk),
        .mod_reset_n (rst_n),
        .enable      (en1),
        .input_sig   (in1),
        .output_sig  (out1),
        .overload    (ovl1),
        .ovld_count  (cnt1)
    );

    function automatic longint msat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_reset();
        m_i1 = 0; m_i2 = 0; m_out = 0; m_st = 0; m_run = 0; m_rec = 0; m_ovc = 0;
    endtask

    // Reference loop (order 2, limit 64, 16 recover cycles); st 0=idle 1=run 2=recover.
    task automatic model_step();
        longint x, fb, n1, n2;
        bit nb;
        x  = longint'($signed(in_sig));
        fb = m_out ? FP : FN;
        if (m_st == 2) begin
            m_out = !m_out;
            if (m_rec == 15) begin
                m_rec = 0;
                m_st  = en ? 1 : 0;
            end else begin
                m_rec++;
            end
        end else if (m_st == 1 && m_run == 64) begin
            m_st = 2; m_rec = 0; m_run = 0; m_i1 = 0; m_i2 = 0;
            if (m_ovc < 255) m_ovc++;
        end else if (en) begin
            n1 = msat(m_i1 + x - fb, 26);
            n2 = msat(m_i2 + m_i1 - fb, 28);
            nb = (n2 >= 0);
            m_run = (nb == m_out) ? m_run + 1 : 1;
            m_i1 = n1; m_i2 = n2; m_out = nb; m_st = 1;
        end else begin
            m_st = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; en1 = 1'b0; in_sig = '0; in1 = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; en1 = 1'b0; in_sig = 24'd1000; in1 = '0;
        @(posedge clk);
        #1;
        total++; if (out2 !== 1'b0) begin bad++; $display("FAIL reset_out: got %0b want 0", out2); end
        total++; if (ovl2 !== 1'b0) begin bad++; $display("FAIL reset_ovl: got %0b want 0", ovl2); end
        total++; if (cnt2 !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt2); end
        total++; if (dut2.int1 !== '0 || dut2.int2 !== '0) begin
            bad++; $display("FAIL reset_int: got %0d/%0d want 0/0", dut2.int1, dut2.int2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        total++; if (dut2.state_q !== StIdle) begin
            bad++; $display("FAIL release_idle: got %0d want %0d", dut2.state_q, StIdle);
        end
        tick();
        total++; if (dut2.state_q !== StRun) begin
            bad++; $display("FAIL first_edge_run: got %0d want %0d", dut2.state_q, StRun);
        end
    endtask

    task automatic test_zero_input();
        int ones = 0, mism = 0;
        bit ovl_seen = 0;
        do_reset();
        en = 1'b1; in_sig = '0;
        for (int t = 0; t < 1024; t++) begin
            tick();
            ones += int'(out2);
            if (ovl2) ovl_seen = 1;
            if (out2 !== m_out) mism++;
        end
        total++; if (ones < 508 || ones > 516) begin
            bad++; $display("FAIL zero_density: got %0d want 512+/-4", ones);
        end
        total++; if (ovl_seen) begin bad++; $display("FAIL zero_no_ovl: got 1 want 0"); end
        total++; if (mism != 0) begin bad++; $display("FAIL zero_model: got %0d diffs want 0", mism); end
    endtask

    task automatic test_half_scale();
        int ones = 0, mism = 0;
        do_reset();
        en = 1'b1; in_sig = 24'h400000;
        for (int t = 0; t < 4096; t++) begin
            tick();
            ones += int'(out2);
            if (out2 !== m_out) mism++;
        end
        total++; if (ones < 3056 || ones > 3088) begin
            bad++; $display("FAIL half_density: got %0d want 3072+/-16", ones);
        end
        total++; if (mism != 0) begin bad++; $display("FAIL half_model: got %0d diffs want 0", mism); end
    endtask

    task automatic test_overload();
        int first_hi = 0, second_hi = 0, hi_len = 0, tog_err = 0, mism = 0;
        logic [7:0] cnt_first = '0, cnt_second = '0;
        bit prev_ovl = 0;
        do_reset();
        en = 1'b1; in_sig = 24'h7fffff;
        for (int t = 1; t <= 160; t++) begin
            tick();
            if (ovl2 && !prev_ovl) begin
                if (first_hi == 0) begin
                    first_hi = t; cnt_first = cnt2;
                end else if (second_hi == 0) begin
                    second_hi = t; cnt_second = cnt2;
                end
            end
            if (ovl2 && first_hi != 0 && second_hi == 0) begin
                hi_len++;
                if (out2 !== 1'((t - first_hi) % 2 == 0)) tog_err++;
            end
            prev_ovl = ovl2;
            if (out2 !== m_out) mism++;
        end
        total++; if (first_hi != 65) begin bad++; $display("FAIL ovl_entry: got %0d want 65", first_hi); end
        total++; if (hi_len != 16) begin bad++; $display("FAIL ovl_len: got %0d want 16", hi_len); end
        total++; if (tog_err != 0) begin bad++; $display("FAIL ovl_toggle: got %0d errs want 0", tog_err); end
        total++; if (cnt_first !== 8'd1) begin bad++; $display("FAIL ovl_cnt1: got %0d want 1", cnt_first); end
        total++; if (second_hi != 147) begin bad++; $display("FAIL ovl_repeat: got %0d want 147", second_hi); end
        total++; if (cnt_second !== 8'd2) begin bad++; $display("FAIL ovl_cnt2: got %0d want 2", cnt_second); end
        total++; if (mism != 0) begin bad++; $display("FAIL ovl_model: got %0d diffs want 0", mism); end
    endtask

    task automatic test_enable_hold();
        int mism = 0, e1 = 0, e2 = 0, eo = 0;
        longint s1, s2;
        bit so;
        do_reset();
        en = 1'b1; in_sig = 24'd3000000;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (out2 !== m_out) mism++;
        end
        en = 1'b0;
        s1 = m_i1; s2 = m_i2; so = m_out;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (longint'(dut2.int1) != s1) e1++;
            if (longint'(dut2.int2) != s2) e2++;
            if (out2 !== so) eo++;
        end
        en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (out2 !== m_out) mism++;
        end
        total++; if (e1 != 0) begin bad++; $display("FAIL hold_int1: got %0d changes want 0", e1); end
        total++; if (e2 != 0) begin bad++; $display("FAIL hold_int2: got %0d changes want 0", e2); end
        total++; if (eo != 0) begin bad++; $display("FAIL hold_out: got %0d changes want 0", eo); end
        total++; if (mism != 0) begin bad++; $display("FAIL hold_resume: got %0d diffs want 0", mism); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; in_sig = 24'h7fffff;
        for (int t = 0; t < 71; t++) tick();
        total++; if (ovl2 !== 1'b1 || out2 !== 1'b1) begin
            bad++; $display("FAIL arst_pre: got ovl=%0b out=%0b want 1/1", ovl2, out2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out2 !== 1'b0) begin bad++; $display("FAIL arst_out: got %0b want 0", out2); end
        total++; if (ovl2 !== 1'b0) begin bad++; $display("FAIL arst_ovl: got %0b want 0", ovl2); end
        total++; if (cnt2 !== 8'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", cnt2); end
        total++; if (dut2.state_q !== StIdle) begin
            bad++; $display("FAIL arst_state: got %0d want %0d", dut2.state_q, StIdle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_order1();
        int mism = 0;
        bit ovl_seen = 0;
        logic want;
        do_reset();
        en1 = 1'b1; in1 = '0;
        for (int t = 1; t <= 200; t++) begin
            tick();
            want = (t <= 2) ? 1'b1 : 1'((t % 2) == 0);
            if (out1 !== want) mism++;
            if (ovl1) ovl_seen = 1;
        end
        total++; if (mism != 0) begin bad++; $display("FAIL order1_pattern: got %0d diffs want 0", mism); end
        total++; if (ovl_seen || cnt1 !== 8'd0) begin
            bad++; $display("FAIL order1_ovl: got ovl=%0b cnt=%0d want 0/0", ovl_seen, cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_zero_input();
        test_half_scale();
        test_overload();
        test_enable_hold();
        test_async_reset();
        test_order1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
